// File: rtl/corral_pkg.sv
// Shared types and glyph constants for the Corral display path.
package corral_pkg;

   typedef enum logic [1:0] {
      SHOW_COWBOY,
      SHOW_HORSE,
      GAP,
      RESULT
   } disp_phase_t;

   localparam logic [6:0] GLYPH_WON   = 7'h39;
   localparam logic [6:0] GLYPH_LOST  = 7'h38;
   localparam logic [6:0] GLYPH_BLANK = 7'h00;

endpackage

// File: rtl/corral_display_seg7_hex.sv
// Combinational hex digit to 7-segment glyph decoder, bit order {g,f,e,d,c,b,a}.
module seg7_hex (
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   // Map each nibble value to its lit segments.
   always_comb begin
      seg_o = 7'h00;
      unique case (hex_i)
         4'h0: seg_o = 7'h3F;
         4'h1: seg_o = 7'h06;
         4'h2: seg_o = 7'h5B;
         4'h3: seg_o = 7'h4F;
         4'h4: seg_o = 7'h66;
         4'h5: seg_o = 7'h6D;
         4'h6: seg_o = 7'h7D;
         4'h7: seg_o = 7'h07;
         4'h8: seg_o = 7'h7F;
         4'h9: seg_o = 7'h6F;
         4'hA: seg_o = 7'h77;
         4'hB: seg_o = 7'h7C;
         4'hC: seg_o = 7'h39;
         4'hD: seg_o = 7'h5E;
         4'hE: seg_o = 7'h79;
         4'hF: seg_o = 7'h71;
         default: seg_o = 7'h00;
      endcase
   end

endmodule

// File: rtl/corral_display.sv
// Corral display stage: multiplexes cowboy / horse / gap phases on one
// 7-segment digit during play and blinks a result glyph after game over.
module corral_display
   import corral_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES = 1000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] cowboyPos,
   input  logic [3:0] horsePos,
   input  logic       gameover,
   input  logic       lostwon,
   input  logic       ready,
   output logic [6:0] segments,
   output logic       dp
);

   localparam int unsigned   CNT_W    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

   disp_phase_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             blink_q, blink_d;
   logic [3:0]       cow_q, cow_d;
   logic [3:0]       horse_q, horse_d;
   logic             rdy_q, rdy_d;
   logic             lw_q, lw_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;

   logic             terminal;
   logic [3:0]       hex_sel;
   logic [6:0]       hex_glyph;

   assign terminal = (cnt_q == CNT_LAST);
   assign segments = seg_q;
   assign dp       = dp_q;

   // The output registers are decoded from next-state values so that the
   // displayed glyph changes on the same edge as the phase it belongs to.
   assign hex_sel = (state_d == SHOW_HORSE) ? horse_d : cow_d;

   seg7_hex u_hex (
      .hex_i (hex_sel),
      .seg_o (hex_glyph)
   );

   // Next-state logic: result entry/exit first, then dwell-terminal advance.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      blink_d = blink_q;
      cow_d   = cow_q;
      horse_d = horse_q;
      rdy_d   = rdy_q;
      lw_d    = lw_q;

      if (state_q != RESULT && gameover) begin
         state_d = RESULT;
         cnt_d   = '0;
         blink_d = 1'b1;
         lw_d    = lostwon;
      end else if (state_q == RESULT && !gameover) begin
         state_d = SHOW_COWBOY;
         cnt_d   = '0;
         cow_d   = cowboyPos;
      end else if (terminal) begin
         cnt_d = '0;
         unique case (state_q)
            SHOW_COWBOY: begin
               state_d = SHOW_HORSE;
               horse_d = horsePos;
            end
            SHOW_HORSE: begin
               state_d = GAP;
               rdy_d   = ready;
            end
            GAP: begin
               state_d = SHOW_COWBOY;
               cow_d   = cowboyPos;
            end
            RESULT: begin
               blink_d = ~blink_q;
            end
            default: state_d = GAP;
         endcase
      end
   end

   // Output decode for the phase being entered or held.
   always_comb begin
      seg_d = GLYPH_BLANK;
      dp_d  = 1'b0;
      unique case (state_d)
         SHOW_COWBOY: begin
            seg_d = hex_glyph;
            dp_d  = 1'b0;
         end
         SHOW_HORSE: begin
            seg_d = hex_glyph;
            dp_d  = 1'b1;
         end
         GAP: begin
            seg_d = GLYPH_BLANK;
            dp_d  = rdy_d;
         end
         RESULT: begin
            seg_d = blink_d ? (lw_d ? GLYPH_WON : GLYPH_LOST) : GLYPH_BLANK;
            dp_d  = 1'b0;
         end
         default: begin
            seg_d = GLYPH_BLANK;
            dp_d  = 1'b0;
         end
      endcase
   end

   // State, latches and output registers; reset parks in GAP on its terminal
   // count so the first released edge enters SHOW_COWBOY.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= GAP;
         cnt_q   <= CNT_LAST;
         blink_q <= 1'b0;
         cow_q   <= '0;
         horse_q <= '0;
         rdy_q   <= 1'b0;
         lw_q    <= 1'b0;
         seg_q   <= GLYPH_BLANK;
         dp_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         blink_q <= blink_d;
         cow_q   <= cow_d;
         horse_q <= horse_d;
         rdy_q   <= rdy_d;
         lw_q    <= lw_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

endmodule

// File: tb/tb_corral_display.sv
// Self-checking bench for corral_display (DWELL_CYCLES=4 and =1 instances).
module tb_corral_display;

   localparam int unsigned MAXE = 4096;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] cow = '0;
   logic [3:0] horse = '0;
   logic       go = 1'b0;
   logic       lw = 1'b0;
   logic       rdy = 1'b0;
   logic [6:0] seg4, seg1;
   logic       dp4, dp1;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   corral_display #(.DWELL_CYCLES(4)) dut4 (
      .clock(clk), .reset(rst), .cowboyPos(cow), .horsePos(horse),
      .gameover(go), .lostwon(lw), .ready(rdy), .segments(seg4), .dp(dp4)
   );

   corral_display #(.DWELL_CYCLES(1)) dut1 (
      .clock(clk), .reset(rst), .cowboyPos(cow), .horsePos(horse),
      .gameover(go), .lostwon(lw), .ready(rdy), .segments(seg1), .dp(dp1)
   );

   // Reference model: input history per edge plus the edge where the current
   // mode (0 reset, 1 play, 2 result) began; outputs derived arithmetically.
   logic [3:0] h_cow   [MAXE];
   logic [3:0] h_horse [MAXE];
   logic       h_rdy   [MAXE];
   logic       h_lw    [MAXE];
   int unsigned ne = 0;
   int unsigned mode   [2] = '{0, 0};
   int unsigned mstart [2] = '{0, 0};
   int unsigned dw     [2] = '{4, 1};
   logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   function automatic logic [7:0] model_out(int unsigned i);
      int unsigned last, k, d, p, entry;
      last = ne - 1;
      d = dw[i];
      if (mode[i] == 0) return 8'h00;
      if (mode[i] == 2) begin
         k = (last - mstart[i]) / d;
         if (k % 2 == 0) return {1'b0, (h_lw[mstart[i]] ? 7'h39 : 7'h38)};
         return 8'h00;
      end
      k = last - mstart[i];
      p = (k / d) % 3;
      entry = mstart[i] + (k / d) * d;
      if (p == 0) return {1'b0, glyph[h_cow[entry]]};
      if (p == 1) return {1'b1, glyph[h_horse[entry]]};
      return {h_rdy[entry], 7'h00};
   endfunction

   task automatic tick();
      int unsigned idx;
      @(posedge clk);
      idx = ne;
      if (idx >= MAXE) begin
         $display("FAIL history_overflow edges=%0d limit=%0d", idx, MAXE);
         errors++;
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $fatal(1, "history overflow");
      end
      h_cow[idx] = cow;
      h_horse[idx] = horse;
      h_rdy[idx] = rdy;
      h_lw[idx] = lw;
      for (int unsigned i = 0; i < 2; i++) begin
         if (rst) mode[i] = 0;
         else if (mode[i] != 2 && go) begin mode[i] = 2; mstart[i] = idx; end
         else if (mode[i] == 2 && !go) begin mode[i] = 1; mstart[i] = idx; end
         else if (mode[i] == 0) begin mode[i] = 1; mstart[i] = idx; end
      end
      ne = idx + 1;
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] exp;
      rst = 1'b1; cow = 4'd3; horse = 4'd10; rdy = 1'b1; go = 1'b0; lw = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if ({dp4, seg4} !== 8'h00) begin
            $display("FAIL reset_hold c=%0d got dp=%b seg=%h want dp=0 seg=00", c, dp4, seg4);
            errors++;
         end
      end
      rst = 1'b0;
      for (int c = 0; c < 24; c++) begin
         tick();
         case ((c / 4) % 3)
            0: exp = {1'b0, 7'h4F};
            1: exp = {1'b1, 7'h77};
            default: exp = {1'b1, 7'h00};
         endcase
         checks++;
         if ({dp4, seg4} !== exp || model_out(0) !== exp) begin
            $display("FAIL reset_seq c=%0d got %h model %h want %h", c, {dp4, seg4}, model_out(0), exp);
            errors++;
         end
      end
   endtask

   task automatic test_midphase();
      logic [7:0] exp;
      tick();
      checks++;
      if ({dp4, seg4} !== {1'b0, 7'h4F}) begin
         $display("FAIL midphase_entry got %h want %h", {dp4, seg4}, {1'b0, 7'h4F});
         errors++;
      end
      cow = 4'd5;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c < 4)       exp = {1'b0, 7'h4F};
         else if (c < 8)  exp = {1'b1, 7'h77};
         else if (c < 12) exp = {1'b1, 7'h00};
         else             exp = {1'b0, 7'h6D};
         checks++;
         if ({dp4, seg4} !== exp || model_out(0) !== exp) begin
            $display("FAIL midphase c=%0d got %h model %h want %h", c, {dp4, seg4}, model_out(0), exp);
            errors++;
         end
      end
   endtask

   task automatic test_result_won();
      logic [7:0] exp;
      repeat (5) tick();   // horse entry, then horse count 1
      go = 1'b1; lw = 1'b1;
      for (int c = 0; c < 16; c++) begin
         tick();
         if (c >= 2) lw = 1'($urandom_range(0, 1));
         exp = ((c / 4) % 2 == 0) ? {1'b0, 7'h39} : 8'h00;
         checks++;
         if ({dp4, seg4} !== exp || model_out(0) !== exp) begin
            $display("FAIL result_won c=%0d got %h model %h want %h", c, {dp4, seg4}, model_out(0), exp);
            errors++;
         end
      end
   endtask

   task automatic test_result_lost();
      logic [7:0] exp;
      go = 1'b0;
      tick();
      checks++;
      if ({dp4, seg4} !== {1'b0, 7'h6D}) begin
         $display("FAIL result_exit got %h want %h", {dp4, seg4}, {1'b0, 7'h6D});
         errors++;
      end
      go = 1'b1; lw = 1'b0;
      tick();
      tick();
      checks++;
      if ({dp4, seg4} !== {1'b0, 7'h38}) begin
         $display("FAIL result_lost got %h want %h", {dp4, seg4}, {1'b0, 7'h38});
         errors++;
      end
      go = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         exp = (c < 4) ? {1'b0, 7'h6D} : {1'b1, 7'h77};
         checks++;
         if ({dp4, seg4} !== exp || model_out(0) !== exp) begin
            $display("FAIL lost_exit c=%0d got %h model %h want %h", c, {dp4, seg4}, model_out(0), exp);
            errors++;
         end
      end
   endtask

   task automatic test_reset_in_result();
      logic [7:0] exp;
      go = 1'b1; lw = 1'b1;
      repeat (3) tick();   // counts 0,1,2 of RESULT
      rst = 1'b1; go = 1'b0; cow = 4'd3; horse = 4'd10; rdy = 1'b1;
      tick();
      checks++;
      if ({dp4, seg4} !== 8'h00) begin
         $display("FAIL reset_in_result got %h want 00", {dp4, seg4});
         errors++;
      end
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         case ((c / 4) % 3)
            0: exp = {1'b0, 7'h4F};
            1: exp = {1'b1, 7'h77};
            default: exp = {1'b1, 7'h00};
         endcase
         checks++;
         if ({dp4, seg4} !== exp || model_out(0) !== exp) begin
            $display("FAIL post_reset c=%0d got %h model %h want %h", c, {dp4, seg4}, model_out(0), exp);
            errors++;
         end
      end
   endtask

   task automatic test_dwell1();
      logic [7:0] exp;
      rst = 1'b1; cow = 4'd15; horse = 4'd0; rdy = 1'b0; go = 1'b0;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 9; c++) begin
         tick();
         case (c % 3)
            0: exp = {1'b0, 7'h71};
            1: exp = {1'b1, 7'h3F};
            default: exp = 8'h00;
         endcase
         checks++;
         if ({dp1, seg1} !== exp || model_out(1) !== exp) begin
            $display("FAIL dwell1 c=%0d got %h model %h want %h", c, {dp1, seg1}, model_out(1), exp);
            errors++;
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 700; c++) begin
         cow = 4'($urandom);
         horse = 4'($urandom);
         rdy = 1'($urandom);
         lw = 1'($urandom);
         if ($urandom_range(0, 29) == 0) go = ~go;
         rst = ($urandom_range(0, 149) == 0);
         tick();
         checks++;
         if ({dp4, seg4} !== model_out(0)) begin
            $display("FAIL random_d4 c=%0d got %h want %h", c, {dp4, seg4}, model_out(0));
            errors++;
         end
         checks++;
         if ({dp1, seg1} !== model_out(1)) begin
            $display("FAIL random_d1 c=%0d got %h want %h", c, {dp1, seg1}, model_out(1));
            errors++;
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_midphase();
      test_result_won();
      test_result_lost();
      test_reset_in_result();
      test_dwell1();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/corral_display.md
# corral_display

Downstream display stage for the Corral game. It consumes the game core's cowboy position, horse position, gameover, lostwon and ready outputs and drives the single 7-segment display plus decimal point. During play it time-multiplexes three phases: cowboy digit, horse digit, and a blank gap. After the game ends it blinks a result glyph. All outputs are registered.

## Interface
- `DWELL_CYCLES`, default 1000: clock cycles spent in each display phase; legal range ≥ 1.
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous reset, active-high.
- `cowboyPos` in 4: cowboy position 0–15, from game core.
- `horsePos` in 4: horse position 0–15, from game core.
- `gameover` in 1: game ended.
- `lostwon` in 1: 1 = horse caught (won), 0 = lost; meaningful only while `gameover`=1.
- `ready` in 1: game core awaiting a move.
- `segments` out 7: segment drive, bit order {g,f,e,d,c,b,a}, 1 = lit.
- `dp` out 1: decimal point, 1 = lit.

## Operation
- States: SHOW_COWBOY, SHOW_HORSE, GAP, RESULT.
- Dwell counter: width max(1, $clog2(DWELL_CYCLES)).
  - Counts 0..DWELL_CYCLES-1.
  - The edge where the count is DWELL_CYCLES-1 is the terminal edge: the counter returns to 0 and the phase advances.
- Play sequence on terminal edges: SHOW_COWBOY → SHOW_HORSE → GAP → SHOW_COWBOY.
- Phase entry: the displayed value is latched on the entry edge and frozen for the whole phase.
  - SHOW_COWBOY latches `cowboyPos`.
  - SHOW_HORSE latches `horsePos`.
  - GAP latches `ready`.
  - Input changes mid-phase are not visible until the next entry of that phase.
- Outputs are registered and loaded on the same edge as the state and latch they reflect, so no extra latency.
  - SHOW_COWBOY: `segments` = hex glyph of the latched value; `dp`=0.
  - SHOW_HORSE: `segments` = hex glyph of the latched value; `dp`=1.
  - GAP: `segments`=0x00; `dp` = latched `ready`.
- Hex glyphs 0–F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- RESULT entry: any edge with `gameover`=1 while not in RESULT.
  - Takes priority over a terminal-edge advance.
  - Counter cleared to 0; blink phase set to ON; `lostwon` latched.
- RESULT display:
  - Blink ON: `segments` = 0x39 ('C', caught) if latched `lostwon`=1, else 0x38 ('L').
  - Blink OFF: `segments`=0x00.
  - `dp`=0 throughout.
  - The blink phase toggles on each terminal edge.
  - `lostwon` changes inside RESULT are ignored.
- RESULT exit: an edge with `gameover`=0 goes to SHOW_COWBOY with counter 0 and latches `cowboyPos`.
- Reset (any edge with `reset`=1, including mid-phase or mid-RESULT):
  - State GAP; counter DWELL_CYCLES-1; latched ready 0; latched values 0.
  - `segments`=0x00, `dp`=0.
- First edge after reset release is a terminal edge in GAP:
  - Enters SHOW_COWBOY and shows `cowboyPos` immediately.
  - If `gameover`=1 on that edge, enters RESULT instead.
- DWELL_CYCLES=1: every edge is terminal, so the phase advances every cycle.

## Timing
- Latency from phase-entry edge to valid `segments`/`dp`: 0 cycles (registered on that edge).
- Latency from `gameover` rising (sampled at edge N) to result glyph: visible after edge N.
- Latency from `gameover` falling (sampled at edge N) to cowboy glyph: visible after edge N.
- Play-cycle period: 3·DWELL_CYCLES.
- Blink period: 2·DWELL_CYCLES.
- Inputs are already synchronous to `clock` (from game core); no synchronizers.
- No handshake: the block only observes the game core and never backpressures it.

## Structure
- Shared package `corral_pkg`:
  - `disp_phase_t` enum: SHOW_COWBOY, SHOW_HORSE, GAP, RESULT.
  - Glyph constants: `GLYPH_WON`=7'h39, `GLYPH_LOST`=7'h38, `GLYPH_BLANK`=7'h00.
- One sub-module `seg7_hex`: combinational 4-bit → 7-bit hex glyph decoder, reusable elsewhere in the design.
- Top level holds the FSM, dwell counter, blink bit, latches and output registers.

## Test plan
All scenarios use DWELL_CYCLES=4.
- Hold `reset` 3 cycles, then release with `cowboyPos`=3, `horsePos`=10, `ready`=1, `gameover`=0 → during reset 0x00/`dp`0; then 0x4F/`dp`0 ×4 cycles, 0x77/`dp`1 ×4, 0x00/`dp`1 ×4, repeating.
- `cowboyPos` 3→5 at count 1 of SHOW_COWBOY → 0x4F held through that phase; next SHOW_COWBOY shows 0x6D.
- `gameover`=1, `lostwon`=1 asserted at count 2 of SHOW_HORSE → next edge 0x39/`dp`0 ×4, then 0x00 ×4, alternating; toggling `lostwon` mid-RESULT has no effect.
- `gameover`=1, `lostwon`=0 → 0x38 blinking; `gameover` drops at count 1 → next edge shows cowboy glyph for a full 4 cycles.
- `reset` asserted at count 2 of RESULT → next edge 0x00/`dp`0; after release, sequence exactly as in the first scenario.
- DWELL_CYCLES=1, `cowboyPos`=15, `horsePos`=0, `ready`=0 → 0x71, 0x3F, 0x00 on consecutive cycles, `dp` 0,1,0.
